// File: rtl/sd_spi_card_emu.sv
// sd_spi_card_emu: SPI-mode SD card responder. Decodes 6-byte commands from the
// host, answers with R1 / read data tokens / write data responses, and moves block
// data through a byte-wide backing-store port.
`timescale 1ns/1ps
module sd_spi_card_emu #(
   parameter int unsigned BLOCK_LEN  = 512,
   parameter int unsigned NCR        = 1,
   parameter int unsigned NAC        = 2,
   parameter int unsigned BUSY_BYTES = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        CS,
   output logic        MISO,
   output logic [31:0] CARD_ADDR,
   output logic [8:0]  CARD_IDX,
   output logic        CARD_RD_STB,
   input  logic [7:0]  CARD_RD_DATA,
   output logic        CARD_WR_STB,
   output logic [7:0]  CARD_WR_DATA,
   output logic        CMD_STB,
   output logic [5:0]  CMD_IDX,
   output logic [31:0] CMD_ARG
);

   localparam logic [8:0] LAST_IDX  = 9'(BLOCK_LEN - 1);
   localparam logic [7:0] NCR_LAST  = 8'(NCR - 1);
   localparam logic [7:0] NAC_LAST  = 8'(NAC - 1);
   localparam logic [7:0] BUSY_LAST = 8'(BUSY_BYTES - 1);

   typedef enum logic [3:0] {
      S_CMD_WAIT, S_CMD_ARG, S_CMD_CRC, S_NCR_GAP, S_R1,
      S_RD_NAC, S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
      S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
   } state_t;

   state_t      state;
   logic [1:0]  sclk_sync, mosi_sync, cs_sync;
   logic        sclk_d;
   logic        rise, fall, byte_done;
   logic [2:0]  bit_cnt;
   logic [6:0]  rx_sh;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_sh;
   logic [7:0]  r1_val;
   logic [7:0]  rd_hold;
   logic [7:0]  gap_cnt;
   logic [8:0]  data_cnt, idx_p1, idx_p2;
   logic [1:0]  stb_d;
   logic        idle, rd_go, wr_go;

   // Two-flop synchronizers for the asynchronous SPI pins plus SCLK edge history
   always_ff @(posedge CLK) begin
      if (RST) begin
         sclk_sync <= '0;
         mosi_sync <= '1;
         cs_sync   <= '1;
         sclk_d    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], SCLK};
         mosi_sync <= {mosi_sync[0], MOSI};
         cs_sync   <= {cs_sync[0], CS};
         sclk_d    <= sclk_sync[1];
      end
   end

   // SCLK edge detect, assembled receive byte and next-index helpers
   always_comb begin
      rise      = sclk_sync[1] & ~sclk_d;
      fall      = ~sclk_sync[1] & sclk_d;
      rx_byte   = {rx_sh, mosi_sync[1]};
      byte_done = rise && (bit_cnt == 3'd7);
      idx_p1    = data_cnt + 9'd1;
      idx_p2    = data_cnt + 9'd2;
   end

   // Bit shifting, byte-level protocol FSM and backing-store strobes
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_CMD_WAIT;
         MISO         <= 1'b1;
         CARD_ADDR    <= '0;
         CARD_IDX     <= '0;
         CARD_RD_STB  <= 1'b0;
         CARD_WR_STB  <= 1'b0;
         CARD_WR_DATA <= '0;
         CMD_STB      <= 1'b0;
         CMD_IDX      <= '0;
         CMD_ARG      <= '0;
         bit_cnt      <= '0;
         rx_sh        <= '0;
         tx_sh        <= '1;
         r1_val       <= '1;
         rd_hold      <= '0;
         gap_cnt      <= '0;
         data_cnt     <= '0;
         stb_d        <= '0;
         idle         <= 1'b1;
         rd_go        <= 1'b0;
         wr_go        <= 1'b0;
      end else begin
         CARD_RD_STB <= 1'b0;
         CARD_WR_STB <= 1'b0;
         CMD_STB     <= 1'b0;
         // store data is only guaranteed on the second cycle after the strobe
         stb_d <= {stb_d[0], CARD_RD_STB};
         if (stb_d[1]) rd_hold <= CARD_RD_DATA;

         if (cs_sync[1]) begin
            bit_cnt <= '0;
            MISO    <= 1'b1;
            tx_sh   <= '1;
            state   <= S_CMD_WAIT;
         end else begin
            if (fall) begin
               MISO  <= tx_sh[7];
               tx_sh <= {tx_sh[6:0], 1'b1};
            end
            if (rise) begin
               rx_sh   <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
            end
            // the byte for the next slot is chosen at the 8th rise of the current one
            if (byte_done) begin
               tx_sh <= 8'hFF;
               case (state)
                  S_CMD_WAIT: begin
                     if (rx_byte[7:6] == 2'b01) begin
                        CMD_IDX <= rx_byte[5:0];
                        gap_cnt <= '0;
                        state   <= S_CMD_ARG;
                     end
                  end
                  S_CMD_ARG: begin
                     CMD_ARG <= {CMD_ARG[23:0], rx_byte};
                     gap_cnt <= gap_cnt + 8'd1;
                     if (gap_cnt == 8'd3) state <= S_CMD_CRC;
                  end
                  S_CMD_CRC: begin
                     CMD_STB <= 1'b1;
                     gap_cnt <= '0;
                     rd_go   <= 1'b0;
                     wr_go   <= 1'b0;
                     state   <= S_NCR_GAP;
                     case (CMD_IDX)
                        6'd0: begin
                           idle   <= 1'b1;
                           r1_val <= 8'h01;
                        end
                        6'd1, 6'd41: begin
                           idle   <= 1'b0;
                           r1_val <= 8'h00;
                        end
                        6'd16, 6'd55: r1_val <= {7'b0, idle};
                        6'd17, 6'd24: begin
                           if (!idle) begin
                              r1_val    <= 8'h00;
                              CARD_ADDR <= CMD_ARG;
                              rd_go     <= (CMD_IDX == 6'd17);
                              wr_go     <= (CMD_IDX == 6'd24);
                           end else begin
                              r1_val <= {5'b0, 1'b1, 1'b0, idle};
                           end
                        end
                        default: r1_val <= {5'b0, 1'b1, 1'b0, idle};
                     endcase
                  end
                  S_NCR_GAP: begin
                     if (gap_cnt == NCR_LAST) begin
                        tx_sh <= r1_val;
                        state <= S_R1;
                     end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                     end
                  end
                  S_R1: begin
                     gap_cnt <= '0;
                     if (rd_go)      state <= S_RD_NAC;
                     else if (wr_go) state <= S_WR_TOKEN;
                     else            state <= S_CMD_WAIT;
                  end
                  S_RD_NAC: begin
                     if (gap_cnt == NAC_LAST) begin
                        tx_sh       <= 8'hFE;
                        data_cnt    <= '0;
                        CARD_IDX    <= '0;
                        CARD_RD_STB <= 1'b1;
                        state       <= S_RD_TOKEN;
                     end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                     end
                  end
                  S_RD_TOKEN: begin
                     tx_sh <= rd_hold;
                     state <= S_RD_DATA;
                     if (data_cnt != LAST_IDX) begin
                        CARD_IDX    <= idx_p1;
                        CARD_RD_STB <= 1'b1;
                     end
                  end
                  S_RD_DATA: begin
                     if (data_cnt == LAST_IDX) begin
                        gap_cnt <= '0;
                        state   <= S_RD_CRC;
                     end else begin
                        tx_sh    <= rd_hold;
                        data_cnt <= idx_p1;
                        // prefetch one byte ahead, but never past the block end
                        if (idx_p1 != LAST_IDX) begin
                           CARD_IDX    <= idx_p2;
                           CARD_RD_STB <= 1'b1;
                        end
                     end
                  end
                  S_RD_CRC: begin
                     if (gap_cnt == 8'd1) state <= S_CMD_WAIT;
                     else                 gap_cnt <= gap_cnt + 8'd1;
                  end
                  S_WR_TOKEN: begin
                     if (rx_byte == 8'hFE) begin
                        data_cnt <= '0;
                        CARD_IDX <= '0;
                        state    <= S_WR_DATA;
                     end else if (rx_byte != 8'hFF) begin
                        state <= S_CMD_WAIT;
                     end
                  end
                  S_WR_DATA: begin
                     CARD_WR_STB  <= 1'b1;
                     CARD_WR_DATA <= rx_byte;
                     CARD_IDX     <= data_cnt;
                     if (data_cnt == LAST_IDX) begin
                        gap_cnt <= '0;
                        state   <= S_WR_CRC;
                     end else begin
                        data_cnt <= idx_p1;
                     end
                  end
                  S_WR_CRC: begin
                     if (gap_cnt == 8'd1) begin
                        tx_sh <= 8'h05;
                        state <= S_WR_RESP;
                     end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                     end
                  end
                  S_WR_RESP: begin
                     tx_sh   <= 8'h00;
                     gap_cnt <= '0;
                     state   <= S_WR_BUSY;
                  end
                  S_WR_BUSY: begin
                     if (gap_cnt == BUSY_LAST) begin
                        state <= S_CMD_WAIT;
                     end else begin
                        tx_sh   <= 8'h00;
                        gap_cnt <= gap_cnt + 8'd1;
                     end
                  end
                  default: state <= S_CMD_WAIT;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_card_emu.sv
// tb_sd_spi_card_emu: SPI host driving the SD card responder; checks MISO bytes
// against an expected-byte queue and backing-store strobes against a write queue.
`timescale 1ns/1ps
module tb_sd_spi_card_emu;

   localparam int H    = 4;     // SCLK half period in CLK cycles
   localparam int BL   = 512;
   localparam int NCRB = 1;
   localparam int NACB = 2;
   localparam int BUSY = 4;

   logic        CLK = 1'b0;
   logic        RST, SCLK, MOSI, CS;
   logic        MISO;
   logic [31:0] CARD_ADDR;
   logic [8:0]  CARD_IDX;
   logic        CARD_RD_STB;
   logic [7:0]  CARD_RD_DATA;
   logic        CARD_WR_STB;
   logic [7:0]  CARD_WR_DATA;
   logic        CMD_STB;
   logic [5:0]  CMD_IDX;
   logic [31:0] CMD_ARG;

   always #5 CLK = ~CLK;

   sd_spi_card_emu #(.BLOCK_LEN(BL), .NCR(NCRB), .NAC(NACB), .BUSY_BYTES(BUSY)) dut (
      .CLK(CLK), .RST(RST), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO),
      .CARD_ADDR(CARD_ADDR), .CARD_IDX(CARD_IDX), .CARD_RD_STB(CARD_RD_STB),
      .CARD_RD_DATA(CARD_RD_DATA), .CARD_WR_STB(CARD_WR_STB), .CARD_WR_DATA(CARD_WR_DATA),
      .CMD_STB(CMD_STB), .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG)
   );

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [7:0]  crc;
      logic [7:0]  r1;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [8:0]  idx;
      logic [7:0]  data;
   } wr_t;

   int          checks = 0;
   int          failures = 0;
   int          cmd_cnt = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [7:0]  exp_q[$];
   wr_t         wq[$];
   wr_t         we;
   logic [31:0] rd_exp_addr = '0;
   logic [8:0]  rd_exp_idx = '0;
   logic        p1v = 1'b0, p2v = 1'b0;
   logic [7:0]  p1d = '0, p2d = '0;

   function automatic logic [7:0] store(input logic [31:0] a, input logic [8:0] k);
      return (k[7:0] + {a[3:0], 4'h3}) ^ {k[8], 7'h2A};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Backing store: data appears exactly on the second cycle after the strobe
   always @(negedge CLK) begin
      CARD_RD_DATA = p2v ? p2d : 8'($urandom);
      p2v = p1v;
      p2d = p1d;
      p1v = CARD_RD_STB;
      p1d = store(CARD_ADDR, CARD_IDX);
   end

   // Strobe monitors
   always @(negedge CLK) begin
      if (CMD_STB) cmd_cnt++;
      if (CARD_RD_STB) begin
         rd_cnt++;
         chk("rd_addr", CARD_ADDR, rd_exp_addr);
         chk("rd_idx", {23'h0, CARD_IDX}, {23'h0, rd_exp_idx});
         rd_exp_idx = rd_exp_idx + 9'd1;
      end
      if (CARD_WR_STB) begin
         wr_cnt++;
         if (wq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_extra actual=strobe idx=0x%0h required=no strobe", CARD_IDX);
         end else begin
            we = wq.pop_front();
            chk("wr_addr", CARD_ADDR, we.addr);
            chk("wr_idx", {23'h0, CARD_IDX}, {23'h0, we.idx});
            chk("wr_data", {24'h0, CARD_WR_DATA}, {24'h0, we.data});
         end
      end
   end

   task automatic xbits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         MOSI = tx[3'(7 - i)];
         repeat (H) @(negedge CLK);
         rx = {rx[6:0], MISO};
         SCLK = 1'b1;
         repeat (H) @(negedge CLK);
         SCLK = 1'b0;
      end
   endtask

   task automatic xbyte(input logic [7:0] tx);
      logic [7:0] rx, exp;
      xbits(tx, 8, rx);
      exp = (exp_q.size() == 0) ? 8'hFF : exp_q.pop_front();
      chk("miso_byte", {24'h0, rx}, {24'h0, exp});
   endtask

   task automatic push_n(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [7:0] crc, input logic [7:0] r1);
      int c0;
      c0 = cmd_cnt;
      push_n(8'hFF, 6 + NCRB);
      exp_q.push_back(r1);
      xbyte({2'b01, idx});
      xbyte(arg[31:24]);
      xbyte(arg[23:16]);
      xbyte(arg[15:8]);
      xbyte(arg[7:0]);
      xbyte(crc);
      for (int i = 0; i < NCRB; i++) xbyte(8'hFF);
      xbyte(8'hFF);
      chk("cmd_stb", 32'(cmd_cnt - c0), 32'd1);
      chk("cmd_idx", {26'h0, CMD_IDX}, {26'h0, idx});
      chk("cmd_arg", CMD_ARG, arg);
   endtask

   initial begin
      #3_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[10];
      int   r0, w0;
      logic [7:0] rx;
      logic [8:0] kk;
      logic [7:0] dd;

      tbl[0] = '{6'd16, 32'd512,        8'h01, 8'h01};
      tbl[1] = '{6'd55, 32'd0,          8'h01, 8'h01};
      tbl[2] = '{6'd24, 32'd0,          8'h01, 8'h05};
      tbl[3] = '{6'd8,  32'h0000_01AA,  8'h87, 8'h05};
      tbl[4] = '{6'd41, 32'h4000_0000,  8'h01, 8'h00};
      tbl[5] = '{6'd59, 32'd0,          8'h01, 8'h04};
      tbl[6] = '{6'd0,  32'd0,          8'h95, 8'h01};
      tbl[7] = '{6'd17, 32'd0,          8'h01, 8'h05};
      tbl[8] = '{6'd1,  32'd0,          8'h01, 8'h00};
      tbl[9] = '{6'd16, 32'd512,        8'h01, 8'h00};

      RST = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b1;
      repeat (4) @(negedge CLK);
      chk("rst_miso", {31'h0, MISO}, 32'd1);
      chk("rst_addr", CARD_ADDR, 32'd0);
      chk("rst_idx", {23'h0, CARD_IDX}, 32'd0);
      chk("rst_cmd_idx", {26'h0, CMD_IDX}, 32'd0);
      chk("rst_cmd_arg", CMD_ARG, 32'd0);
      chk("rst_wr_data", {24'h0, CARD_WR_DATA}, 32'd0);
      chk("rst_stbs", {29'h0, CARD_RD_STB, CARD_WR_STB, CMD_STB}, 32'd0);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      CS = 1'b0;
      repeat (8) @(negedge CLK);

      // command / R1 table; trailing bytes must stay 0xFF with no data traffic
      for (int v = 0; v < 10; v++) begin
         r0 = rd_cnt;
         w0 = wr_cnt;
         send_cmd(tbl[v].idx, tbl[v].arg, tbl[v].crc, tbl[v].r1);
         push_n(8'hFF, 3);
         for (int i = 0; i < 3; i++) xbyte(8'hFF);
         chk("tbl_no_rd", 32'(rd_cnt - r0), 32'd0);
         chk("tbl_no_wr", 32'(wr_cnt - w0), 32'd0);
      end

      // single block read
      rd_exp_addr = 32'h10;
      rd_exp_idx  = '0;
      r0 = rd_cnt;
      send_cmd(6'd17, 32'h10, 8'h01, 8'h00);
      push_n(8'hFF, NACB);
      exp_q.push_back(8'hFE);
      for (int k = 0; k < BL; k++) exp_q.push_back(store(32'h10, 9'(k)));
      push_n(8'hFF, 3);
      for (int i = 0; i < NACB + 1 + BL + 3; i++) xbyte(8'hFF);
      chk("rd_count", 32'(rd_cnt - r0), 32'(BL));
      chk("rd_card_addr", CARD_ADDR, 32'h10);

      // single block write
      w0 = wr_cnt;
      send_cmd(6'd24, 32'd7, 8'h01, 8'h00);
      push_n(8'hFF, 2);
      xbyte(8'hFF);
      xbyte(8'hFE);
      for (int k = 0; k < BL; k++) begin
         kk = 9'(k);
         wq.push_back('{32'd7, kk, kk[7:0]});
         exp_q.push_back(8'hFF);
         xbyte(kk[7:0]);
      end
      push_n(8'hFF, 2);
      exp_q.push_back(8'h05);
      push_n(8'h00, BUSY);
      push_n(8'hFF, 2);
      for (int i = 0; i < 2 + 1 + BUSY + 2; i++) xbyte(8'hFF);
      chk("wr_count", 32'(wr_cnt - w0), 32'(BL));
      chk("wr_q_empty", 32'(wq.size()), 32'd0);

      // write aborted by CS after 100 bytes
      w0 = wr_cnt;
      send_cmd(6'd24, 32'd9, 8'h01, 8'h00);
      push_n(8'hFF, 2);
      xbyte(8'hFF);
      xbyte(8'hFE);
      for (int k = 0; k < 100; k++) begin
         kk = 9'(k);
         dd = 8'(k * 7 + 1);
         wq.push_back('{32'd9, kk, dd});
         exp_q.push_back(8'hFF);
         xbyte(dd);
      end
      repeat (6) @(negedge CLK);
      CS = 1'b1;
      repeat (16) @(negedge CLK);
      chk("abort_miso", {31'h0, MISO}, 32'd1);
      CS = 1'b0;
      repeat (8) @(negedge CLK);
      send_cmd(6'd0, 32'd0, 8'h95, 8'h01);
      push_n(8'hFF, 2);
      xbyte(8'hFF);
      xbyte(8'hFF);
      chk("abort_wr_count", 32'(wr_cnt - w0), 32'd100);
      chk("abort_q_empty", 32'(wq.size()), 32'd0);

      // reset in the middle of a read, while the token's last bit drives MISO low
      send_cmd(6'd1, 32'd0, 8'h01, 8'h00);
      rd_exp_addr = 32'h22;
      rd_exp_idx  = '0;
      send_cmd(6'd17, 32'h22, 8'h01, 8'h00);
      push_n(8'hFF, NACB);
      for (int i = 0; i < NACB; i++) xbyte(8'hFF);
      xbits(8'hFF, 7, rx);
      chk("token_bits", {25'h0, rx[6:0]}, 32'h7F);
      repeat (H) @(negedge CLK);
      chk("pre_rst_miso", {31'h0, MISO}, 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_mid_miso", {31'h0, MISO}, 32'd1);
      chk("rst_mid_addr", CARD_ADDR, 32'd0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      CS = 1'b1;
      repeat (8) @(negedge CLK);
      CS = 1'b0;
      repeat (8) @(negedge CLK);
      send_cmd(6'd16, 32'd512, 8'h01, 8'h01);
      push_n(8'hFF, 1);
      xbyte(8'hFF);

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
